// File: rtl/sdrctrl_package.sv
// Shared SDRAM-controller definitions: Wishbone widths, cycle-type codes and
// the arbiter state encoding.
package sdrctrl_package;

    localparam int unsigned WB_AW = 26;
    localparam int unsigned WB_DW = 32;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_TMO
    } arb_state_t;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts consecutive strobe-without-ack cycles and flags a timeout on the
// last allowed cycle so the arbiter can step into its error state.
module wb_ack_watchdog #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_CYC = 200
) (
    input  logic sys_clk,
    input  logic RESETN,
    input  logic en,
    input  logic stb,
    input  logic ack,
    output logic timeout
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             counting;

    always_comb begin
        counting = en & stb & ~ack;
        timeout  = counting & (cnt_q == TMO_LAST);
        cnt_d    = '0;
        if (counting && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_sdrc_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the SDRAM controller
// slave port, with grant gating on init-done and an ack watchdog.
module wb_sdrc_arbiter
    import sdrctrl_package::*;
#(
    parameter int unsigned aw      = WB_AW,
    parameter int unsigned dw      = WB_DW,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_CYC = 200
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            sdr_init_done,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [aw-1:0]   m0_addr_i,
    input  logic [dw-1:0]   m0_dat_i,
    input  logic [dw/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    output logic [dw-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [aw-1:0]   m1_addr_i,
    input  logic [dw-1:0]   m1_dat_i,
    input  logic [dw/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    output logic [dw-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [aw-1:0]   wb_addr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    output logic [1:0]      gnt_o
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [1:0] gnt_q, gnt_d;
    logic       req0, req1, winner, own_cyc, busy, timeout;

    wb_ack_watchdog #(
        .TMO_W  (TMO_W),
        .TMO_CYC(TMO_CYC)
    ) u_watchdog (
        .sys_clk(sys_clk),
        .RESETN (RESETN),
        .en     (busy),
        .stb    (wb_stb_o),
        .ack    (wb_ack_i),
        .timeout(timeout)
    );

    // Slave-side mux; everything is forced to 0 outside BUSY so reset and
    // idle present a quiet bus and stray acks never reach a master.
    always_comb begin
        busy      = (state_q == ARB_BUSY);
        own_cyc   = owner_q ? m1_cyc_i : m0_cyc_i;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        wb_cti_o  = '0;
        m0_dat_o  = '0;
        m1_dat_o  = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_err_o  = 1'b0;
        if (busy) begin
            wb_cyc_o  = own_cyc;
            wb_stb_o  = own_cyc & (owner_q ? m1_stb_i : m0_stb_i);
            wb_we_o   = owner_q ? m1_we_i : m0_we_i;
            wb_addr_o = owner_q ? m1_addr_i : m0_addr_i;
            wb_dat_o  = owner_q ? m1_dat_i : m0_dat_i;
            wb_sel_o  = owner_q ? m1_sel_i : m0_sel_i;
            wb_cti_o  = owner_q ? m1_cti_i : m0_cti_i;
            m0_dat_o  = wb_dat_i;
            m1_dat_o  = wb_dat_i;
            m0_ack_o  = ~owner_q & own_cyc & wb_ack_i;
            m1_ack_o  = owner_q & own_cyc & wb_ack_i;
        end else if (state_q == ARB_TMO) begin
            m0_err_o = ~owner_q;
            m1_err_o = owner_q;
        end
    end

    always_comb begin
        req0         = m0_cyc_i & m0_stb_i;
        req1         = m1_cyc_i & m1_stb_i;
        winner       = (req0 && req1) ? ~last_owner_q : req1;
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (sdr_init_done && (req0 || req1)) begin
                    state_d = ARB_BUSY;
                    owner_d = winner;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                end
            end
            ARB_BUSY: begin
                // Release takes priority over a coincident timeout.
                if (!own_cyc) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                    gnt_d        = 2'b00;
                end else if (timeout) begin
                    state_d = ARB_TMO;
                end
            end
            ARB_TMO: begin
                state_d      = ARB_IDLE;
                last_owner_d = owner_q;
                gnt_d        = 2'b00;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Directed bench for wb_sdrc_arbiter: init gating, round-robin, bursts,
// write/read routing, ack timeout and asynchronous reset.
module tb_wb_sdrc_arbiter;
    import sdrctrl_package::*;

    logic        sys_clk = 1'b0;
    logic        RESETN;
    logic        sdr_init_done;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [25:0] m0_addr_i, m1_addr_i, wb_addr_o;
    logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, wb_dat_o, wb_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i, wb_sel_o;
    logic [2:0]  m0_cti_i, m1_cti_i, wb_cti_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [1:0]  gnt_o;
    logic [31:0] slave_mem;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    wb_sdrc_arbiter #(
        .aw(26), .dw(32), .TMO_W(8), .TMO_CYC(200)
    ) dut (
        .sys_clk(sys_clk), .RESETN(RESETN), .sdr_init_done(sdr_init_done),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_cti_i(m0_cti_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_cti_i(m1_cti_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .gnt_o(gnt_o)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_dat_i = '0;
        m0_sel_i = '0; m0_cti_i = CTI_CLASSIC;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_dat_i = '0;
        m1_sel_i = '0; m1_cti_i = CTI_CLASSIC;
        wb_ack_i = 0; wb_dat_i = '0;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        #3;
        RESETN = 1'b1;
    endtask

    task automatic test_reset();
        idle_masters();
        sdr_init_done = 0;
        RESETN = 1'b0;
        wb_ack_i = 1; wb_dat_i = 32'h1234_5678;
        #2;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
        total++; if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b exp=0", wb_cyc_o); end
        total++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b exp=00", m0_ack_o, m1_ack_o); end
        total++; if (m0_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", m0_dat_o); end
        wb_ack_i = 0; wb_dat_i = '0;
        #1 RESETN = 1'b1;
    endtask

    task automatic test_init_gate();
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 26'h10;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (gnt_o !== 2'b00 || wb_cyc_o !== 1'b0) begin bad++; $display("FAIL init_block got=%b/%b exp=00/0", gnt_o, wb_cyc_o); end
        end
        sdr_init_done = 1;
        tick(); #1;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL init_grant got=%b exp=01", gnt_o); end
        total++; if (wb_cyc_o !== 1'b1 || wb_addr_o !== 26'h10) begin bad++; $display("FAIL init_mux got=%b/%h exp=1/10", wb_cyc_o, wb_addr_o); end
        m0_cyc_i = 0; m0_stb_i = 0; #1;
        total++; if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL release_comb got=%b exp=0", wb_cyc_o); end
        tick(); #1;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL release_gnt got=%b exp=00", gnt_o); end
    endtask

    task automatic test_round_robin();
        idle_masters();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 26'h111;
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 26'h222;
        tick(); #1;
        total++; if (gnt_o !== 2'b01 || wb_addr_o !== 26'h111) begin bad++; $display("FAIL rr_first got=%b/%h exp=01/111", gnt_o, wb_addr_o); end
        total++; if (m1_ack_o !== 1'b0) begin bad++; $display("FAIL rr_m1ack got=%b exp=0", m1_ack_o); end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick(); #1;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rr_gap got=%b exp=00", gnt_o); end
        tick(); #1;
        total++; if (gnt_o !== 2'b10 || wb_addr_o !== 26'h222) begin bad++; $display("FAIL rr_second got=%b/%h exp=10/222", gnt_o, wb_addr_o); end
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
    endtask

    task automatic test_burst();
        logic [25:0] exp_addr;
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 26'h100; m0_cti_i = CTI_INCR;
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 26'h300;
        tick(); #1;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL burst_grant got=%b exp=01", gnt_o); end
        for (int i = 0; i < 8; i++) begin
            exp_addr  = 26'h100 + 26'(i * 4);
            m0_addr_i = exp_addr;
            m0_cti_i  = (i == 7) ? CTI_EOB : CTI_INCR;
            wb_ack_i  = 1; wb_dat_i = 32'hA000_0000 + 32'(i);
            #1;
            total++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin bad++; $display("FAIL burst_ack beat=%0d got=%b%b exp=10", i, m0_ack_o, m1_ack_o); end
            total++; if (wb_addr_o !== exp_addr || m0_dat_o !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL burst_data beat=%0d got=%h/%h", i, wb_addr_o, m0_dat_o); end
            total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL burst_hold beat=%0d got=%b exp=01", i, gnt_o); end
            tick();
        end
        total++; if (wb_cti_o !== CTI_EOB) begin bad++; $display("FAIL burst_cti got=%b exp=111", wb_cti_o); end
        m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = CTI_CLASSIC; wb_ack_i = 0;
        tick(); #1;
        total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL burst_release got=%b exp=00", gnt_o); end
        tick(); #1;
        total++; if (gnt_o !== 2'b10 || wb_addr_o !== 26'h300) begin bad++; $display("FAIL burst_m1 got=%b/%h exp=10/300", gnt_o, wb_addr_o); end
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
    endtask

    task automatic test_write_read();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 26'h40;
        m1_dat_i = 32'hDEAD_BEEF; m1_sel_i = 4'hF;
        tick(); #1;
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL wr_grant got=%b exp=10", gnt_o); end
        total++; if (wb_we_o !== 1'b1 || wb_addr_o !== 26'h40 || wb_sel_o !== 4'hF) begin bad++; $display("FAIL wr_ctrl got=%b/%h/%h exp=1/40/f", wb_we_o, wb_addr_o, wb_sel_o); end
        total++; if (wb_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef", wb_dat_o); end
        wb_ack_i = 1; #1;
        slave_mem = wb_dat_o;
        total++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b%b exp=01", m0_ack_o, m1_ack_o); end
        tick();
        m1_we_i = 0; m1_dat_i = '0; wb_dat_i = slave_mem; wb_ack_i = 1; #1;
        total++; if (m1_dat_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b1) begin bad++; $display("FAIL rd_data got=%h/%b exp=deadbeef/1", m1_dat_o, m1_ack_o); end
        total++; if (m0_ack_o !== 1'b0 || wb_we_o !== 1'b0) begin bad++; $display("FAIL rd_ctrl got=%b/%b exp=0/0", m0_ack_o, wb_we_o); end
        tick();
        m1_cyc_i = 0; m1_stb_i = 0; wb_ack_i = 0; wb_dat_i = '0;
        tick();
    endtask

    task automatic test_timeout();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 26'h500;
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 26'h600;
        tick(); #1;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL tmo_grant got=%b exp=01", gnt_o); end
        for (int i = 0; i < 200; i++) begin
            total++; if (m0_err_o !== 1'b0 || wb_cyc_o !== 1'b1) begin bad++; $display("FAIL tmo_early cyc=%0d got=%b/%b exp=0/1", i, m0_err_o, wb_cyc_o); end
            tick(); #1;
        end
        total++; if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0) begin bad++; $display("FAIL tmo_err got=%b%b exp=10", m0_err_o, m1_err_o); end
        total++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || m0_ack_o !== 1'b0) begin bad++; $display("FAIL tmo_bus got=%b/%b/%b exp=0/0/0", wb_cyc_o, wb_stb_o, m0_ack_o); end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick(); #1;
        total++; if (m0_err_o !== 1'b0 || gnt_o !== 2'b00) begin bad++; $display("FAIL tmo_pulse got=%b/%b exp=0/00", m0_err_o, gnt_o); end
        tick(); #1;
        total++; if (gnt_o !== 2'b10 || wb_addr_o !== 26'h600) begin bad++; $display("FAIL tmo_next got=%b/%h exp=10/600", gnt_o, wb_addr_o); end
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 26'h700; m1_cti_i = CTI_INCR;
        tick(); #1;
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL mid_grant got=%b exp=10", gnt_o); end
        wb_ack_i = 1; wb_dat_i = 32'h5555_AAAA; #1;
        total++; if (m1_ack_o !== 1'b1) begin bad++; $display("FAIL mid_ack got=%b exp=1", m1_ack_o); end
        RESETN = 1'b0; #1;
        total++; if (gnt_o !== 2'b00 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin bad++; $display("FAIL mid_rst_bus got=%b/%b/%b exp=00/0/0", gnt_o, wb_cyc_o, wb_stb_o); end
        total++; if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0 || m1_err_o !== 1'b0) begin bad++; $display("FAIL mid_rst_m1 got=%b/%h/%b exp=0/0/0", m1_ack_o, m1_dat_o, m1_err_o); end
        RESETN = 1'b1;
        wb_ack_i = 0; wb_dat_i = '0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 26'h800;
        tick(); #1;
        total++; if (gnt_o !== 2'b01 || wb_addr_o !== 26'h800) begin bad++; $display("FAIL mid_after got=%b/%h exp=01/800", gnt_o, wb_addr_o); end
        idle_masters();
        tick();
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_round_robin();
        test_burst();
        test_write_read();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
